// File: rtl/display_scan_mux.sv
// Time-multiplexed N-digit display scanner with a double-buffered digit snapshot.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is never blanked).
module display_scan_mux #(
   parameter int unsigned NUM_DIGITS = 3,
   parameter int unsigned DIGIT_W    = 4,
   parameter int unsigned PRESCALE   = 50000,
   localparam int unsigned IDX_W     = $clog2(NUM_DIGITS)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic                          load,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
   output logic [DIGIT_W-1:0]            digit_out,
   output logic [NUM_DIGITS-1:0]         digit_sel,
   output logic [IDX_W-1:0]              sel_idx,
   output logic                          scan_tick
);

   localparam int unsigned CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned DATA_W = NUM_DIGITS * DIGIT_W;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_W-1:0]     active_q, active_d;
   logic [DATA_W-1:0]     pending_q, pending_d;
   logic                  pend_v_q, pend_v_d;

   logic [DIGIT_W-1:0]    digit_out_q, digit_out_d;
   logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
   logic [IDX_W-1:0]      sel_idx_q, sel_idx_d;
   logic                  scan_tick_q, scan_tick_d;

   logic                  tick;
   logic                  frame_end;
   logic [DIGIT_W-1:0]    cur_digit;
   logic [NUM_DIGITS-1:0] blank;
   logic                  slot_blank;
`ifdef LEADING_ZERO_BLANK_EN
   logic                  zero_run;
`endif

   always_comb begin : next_state
      tick      = en && (cnt_q == CNT_W'(PRESCALE - 1));
      frame_end = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

      cnt_d = cnt_q;
      idx_d = idx_q;
      if (!en) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (tick) begin
         cnt_d = '0;
         idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // New data only reaches the active buffer at a frame boundary while scanning;
      // a load landing exactly on the boundary is newer than anything pending.
      active_d  = active_q;
      pending_d = pending_q;
      pend_v_d  = pend_v_q;
      if (load && (!en || frame_end)) begin
         active_d = digits_in;
         pend_v_d = 1'b0;
      end else if (load) begin
         pending_d = digits_in;
         pend_v_d  = 1'b1;
      end else if (frame_end && pend_v_q) begin
         active_d = pending_q;
         pend_v_d = 1'b0;
      end
   end

   always_comb begin : outputs_next
      cur_digit = active_q[int'(idx_q) * DIGIT_W +: DIGIT_W];

      blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
      zero_run = 1'b1;
      for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
         zero_run = zero_run && (active_q[i * DIGIT_W +: DIGIT_W] == '0);
         blank[i] = zero_run;
      end
`endif
      slot_blank = blank[idx_q];

      digit_sel_d = (en && !slot_blank) ? (NUM_DIGITS'(1) << idx_q) : '0;
      digit_out_d = slot_blank ? '0 : cur_digit;
      sel_idx_d   = idx_q;
      scan_tick_d = tick;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         active_q    <= '0;
         pending_q   <= '0;
         pend_v_q    <= 1'b0;
         digit_out_q <= '0;
         digit_sel_q <= '0;
         sel_idx_q   <= '0;
         scan_tick_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         active_q    <= active_d;
         pending_q   <= pending_d;
         pend_v_q    <= pend_v_d;
         digit_out_q <= digit_out_d;
         digit_sel_q <= digit_sel_d;
         sel_idx_q   <= sel_idx_d;
         scan_tick_q <= scan_tick_d;
      end
   end

   assign digit_out = digit_out_q;
   assign digit_sel = digit_sel_q;
   assign sel_idx   = sel_idx_q;
   assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: a PRESCALE=4 and a PRESCALE=1 instance share stimulus and
// are checked every cycle against a cycle-count based model plus directed literals.
module tb_display_scan_mux;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [11:0] din = '0;

   logic [3:0]  d_out  [2];
   logic [2:0]  d_sel  [2];
   logic [1:0]  d_idx  [2];
   logic        d_tick [2];

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   display_scan_mux #(.NUM_DIGITS(3), .DIGIT_W(4), .PRESCALE(4)) u_dut_p4 (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(din),
      .digit_out(d_out[0]), .digit_sel(d_sel[0]), .sel_idx(d_idx[0]), .scan_tick(d_tick[0])
   );

   display_scan_mux #(.NUM_DIGITS(3), .DIGIT_W(4), .PRESCALE(1)) u_dut_p1 (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(din),
      .digit_out(d_out[1]), .digit_sel(d_sel[1]), .sel_idx(d_idx[1]), .scan_tick(d_tick[1])
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: k counts enabled edges since the last disable/reset; the slot shown after
   // edge k is floor(k/P) mod 3 and a frame boundary falls on edges where (k+1)%(3P)==0.
   int          mk     [2] = '{0, 0};
   logic [11:0] m_act  [2] = '{12'h0, 12'h0};
   logic [11:0] m_pend [2] = '{12'h0, 12'h0};
   bit          m_pv   [2] = '{1'b0, 1'b0};
   int          e_out  [2] = '{0, 0};
   int          e_sel  [2] = '{0, 0};
   int          e_idx  [2] = '{0, 0};
   int          e_tick [2] = '{0, 0};
   int          mp, mslot, mdig;
   bit          mfend;

   always @(posedge clk or negedge rst_n) begin
      for (int m = 0; m < 2; m++) begin
         if (!rst_n) begin
            mk[m] = 0; m_act[m] = '0; m_pend[m] = '0; m_pv[m] = 1'b0;
            e_out[m] = 0; e_sel[m] = 0; e_idx[m] = 0; e_tick[m] = 0;
         end else begin
            mp    = (m == 0) ? 4 : 1;
            mslot = (mk[m] / mp) % 3;
            mdig  = int'((m_act[m] >> (4 * mslot)) & 12'hF);
            e_idx[m]  = mslot;
            e_tick[m] = (en && ((mk[m] + 1) % mp == 0)) ? 1 : 0;
            e_sel[m]  = en ? (1 << mslot) : 0;
            e_out[m]  = mdig;
`ifdef LEADING_ZERO_BLANK_EN
            if (mslot > 0 && (m_act[m] >> (4 * mslot)) == 0) begin
               e_sel[m] = 0;
               e_out[m] = 0;
            end
`endif
            mfend = en && ((mk[m] + 1) % (3 * mp) == 0);
            if (load && (!en || mfend)) begin
               m_act[m] = din; m_pv[m] = 1'b0;
            end else if (load) begin
               m_pend[m] = din; m_pv[m] = 1'b1;
            end else if (mfend && m_pv[m]) begin
               m_act[m] = m_pend[m]; m_pv[m] = 1'b0;
            end
            mk[m] = en ? mk[m] + 1 : 0;
         end
      end
   end

   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("model[%0d] digit_out", m), int'(d_out[m]), e_out[m]);
         chk($sformatf("model[%0d] digit_sel", m), int'(d_sel[m]), e_sel[m]);
         chk($sformatf("model[%0d] sel_idx", m), int'(d_idx[m]), e_idx[m]);
         chk($sformatf("model[%0d] scan_tick", m), int'(d_tick[m]), e_tick[m]);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      step(2);
      chk("reset sel", int'(d_sel[0]), 0);
      chk("reset out", int'(d_out[0]), 0);
      chk("reset tick", int'(d_tick[0]), 0);
      rst_n = 1'b1;
      step(2);
      chk("idle sel", int'(d_sel[0]), 0);

      load = 1'b1; din = 12'h123;
      step(1);                                   // N0
      load = 1'b0; en = 1'b1;
      step(1);                                   // N1
      chk("scan k0 sel", int'(d_sel[0]), 1);
      chk("scan k0 out", int'(d_out[0]), 3);
      chk("scan k0 tick", int'(d_tick[0]), 0);
      chk("p1 k0 sel", int'(d_sel[1]), 1);
      chk("p1 k0 tick", int'(d_tick[1]), 1);
      step(1);                                   // N2
      chk("p1 k1 sel", int'(d_sel[1]), 2);
      chk("p1 k1 out", int'(d_out[1]), 2);
      step(1);                                   // N3
      chk("p1 k2 sel", int'(d_sel[1]), 4);
      chk("p1 k2 out", int'(d_out[1]), 1);
      step(1);                                   // N4
      chk("scan k3 tick", int'(d_tick[0]), 1);
      chk("scan k3 sel", int'(d_sel[0]), 1);
      chk("p1 wrap sel", int'(d_sel[1]), 1);
      step(1);                                   // N5
      chk("scan slot1 sel", int'(d_sel[0]), 2);
      chk("scan slot1 out", int'(d_out[0]), 2);
      step(4);                                   // N9
      chk("scan slot2 sel", int'(d_sel[0]), 4);
      chk("scan slot2 out", int'(d_out[0]), 1);
      chk("scan slot2 idx", int'(d_idx[0]), 2);
      step(4);                                   // N13
      chk("wrap sel", int'(d_sel[0]), 1);
      chk("wrap out", int'(d_out[0]), 3);
      load = 1'b1; din = 12'h456;
      step(1);                                   // N14
      load = 1'b0;
      step(3);                                   // N17
      chk("buf old slot1", int'(d_out[0]), 2);
      step(4);                                   // N21
      chk("buf old slot2", int'(d_out[0]), 1);
      step(4);                                   // N25
      chk("buf new slot0", int'(d_out[0]), 6);
      step(4);                                   // N29
      chk("buf new slot1", int'(d_out[0]), 5);
      step(4);                                   // N33
      chk("buf new slot2", int'(d_out[0]), 4);
      step(2);                                   // N35
      load = 1'b1; din = 12'h789;
      step(1);                                   // N36
      load = 1'b0;
      chk("coinc tick", int'(d_tick[0]), 1);
      step(1);                                   // N37
      chk("coinc slot0", int'(d_out[0]), 9);
      step(4);                                   // N41
      chk("coinc slot1", int'(d_out[0]), 8);
      step(4);                                   // N45
      chk("coinc slot2", int'(d_out[0]), 7);
      load = 1'b1; din = 12'h321;
      step(1);                                   // N46
      din = 12'h654;
      step(1);                                   // N47
      load = 1'b0;
      step(2);                                   // N49
      chk("overwrite slot0", int'(d_out[0]), 4);
      step(1);                                   // N50
      en = 1'b0;
      step(1);                                   // N51
      chk("disable sel", int'(d_sel[0]), 0);
      chk("disable tick", int'(d_tick[0]), 0);

      step(1);                                   // N52
      load = 1'b1; din = 12'h005;
      step(1);                                   // N53
      load = 1'b0; en = 1'b1;
      step(1);                                   // N54
      chk("blank slot0 sel", int'(d_sel[0]), 1);
      chk("blank slot0 out", int'(d_out[0]), 5);
      step(4);                                   // N58
`ifdef LEADING_ZERO_BLANK_EN
      chk("blank slot1 sel", int'(d_sel[0]), 0);
`else
      chk("blank slot1 sel", int'(d_sel[0]), 2);
`endif
      chk("blank slot1 out", int'(d_out[0]), 0);
      step(4);                                   // N62
`ifdef LEADING_ZERO_BLANK_EN
      chk("blank slot2 sel", int'(d_sel[0]), 0);
`else
      chk("blank slot2 sel", int'(d_sel[0]), 4);
`endif
      step(1);                                   // N63
      en = 1'b0; load = 1'b1; din = 12'h000;
      step(1);                                   // N64
      load = 1'b0; en = 1'b1;
      step(1);                                   // N65
      chk("zero slot0 sel", int'(d_sel[0]), 1);
      chk("zero slot0 out", int'(d_out[0]), 0);
      step(5);                                   // N70

      #2 rst_n = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("async rst[%0d] sel", m), int'(d_sel[m]), 0);
         chk($sformatf("async rst[%0d] out", m), int'(d_out[m]), 0);
         chk($sformatf("async rst[%0d] idx", m), int'(d_idx[m]), 0);
         chk($sformatf("async rst[%0d] tick", m), int'(d_tick[m]), 0);
      end
      en = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(3);
      chk("post rst sel", int'(d_sel[0]), 0);
      chk("post rst idx", int'(d_idx[0]), 0);

      en = 1'b1;
      for (int i = 0; i < 80; i++) begin
         load = ($urandom_range(0, 5) == 0);
         din  = 12'($urandom_range(0, 4095));
         if (i == 40) en = 1'b0;
         if (i == 44) en = 1'b1;
         step(1);
      end
      load = 1'b0;
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
